// File: rtl/flt2int_seq.sv
// Sequential half-precision float to int16 converter: reads the float from
// data memory bytes 4/5, converts with an iterative shifter, writes bytes 6/7.
module flt2int_seq #(
    parameter int MEM_AW = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        mem_rd_data,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    output logic              halt
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        ARMED  = 4'd1,
        RD_HI  = 4'd2,
        RD_LO  = 4'd3,
        DECODE = 4'd4,
        SHIFT  = 4'd5,
        FINAL  = 4'd6,
        WR_HI  = 4'd7,
        WR_LO  = 4'd8,
        DONE   = 4'd9
    } state_t;

    localparam logic [MEM_AW-1:0] ADDR_ZERO = MEM_AW'(0);
    localparam logic [MEM_AW-1:0] ADDR_F_HI = MEM_AW'(4);
    localparam logic [MEM_AW-1:0] ADDR_F_LO = MEM_AW'(5);
    localparam logic [MEM_AW-1:0] ADDR_R_HI = MEM_AW'(6);
    localparam logic [MEM_AW-1:0] ADDR_R_LO = MEM_AW'(7);

    state_t             state_r, state_next_s;
    logic [15:0]        flt_r, shreg_r, result_r, result_s;
    logic [3:0]         cnt_r, n_s;
    logic               left_r, sat_r, left_s, sat_s, zero_s;
    logic [4:0]         e_s;
    logic signed [5:0]  exp_s, diff_s;
    logic [10:0]        mant_s;
    logic [MEM_AW-1:0]  mem_addr_r;
    logic               mem_wr_en_r, halt_r;
    logic [7:0]         mem_wr_data_r;

    // Decode the captured float into shift count, direction and special cases
    always_comb begin
        e_s    = flt_r[14:10];
        exp_s  = $signed({1'b0, e_s}) - 6'sd15;
        mant_s = {|e_s, flt_r[9:0]};
        diff_s = 6'sd0;
        left_s = 1'b0;
        sat_s  = 1'b0;
        zero_s = 1'b0;
        if (exp_s < 6'sd0) begin
            zero_s = 1'b1;
        end else if (exp_s <= 6'sd10) begin
            diff_s = 6'sd10 - exp_s;
        end else if (exp_s <= 6'sd14) begin
            diff_s = exp_s - 6'sd10;
            left_s = 1'b1;
        end else begin
            sat_s = 1'b1;
        end
        n_s = diff_s[3:0];
    end

    // Signed result from the shifted magnitude; -0 wraps naturally to 0
    always_comb begin
        result_s = shreg_r;
        if (sat_r) begin
            result_s = flt_r[15] ? 16'h8000 : 16'h7FFF;
        end else if (flt_r[15]) begin
            result_s = ~shreg_r + 16'd1;
        end else begin
            result_s = shreg_r;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = start ? ARMED : IDLE;
            ARMED:   state_next_s = start ? ARMED : RD_HI;
            RD_HI:   state_next_s = RD_LO;
            RD_LO:   state_next_s = DECODE;
            DECODE:  state_next_s = (n_s != 4'd0) ? SHIFT : FINAL;
            SHIFT:   state_next_s = (cnt_r <= 4'd1) ? FINAL : SHIFT;
            FINAL:   state_next_s = WR_HI;
            WR_HI:   state_next_s = WR_LO;
            WR_LO:   state_next_s = DONE;
            DONE:    state_next_s = start ? ARMED : DONE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: operand capture, iterative shifter and result latch
    always_ff @(posedge CLK) begin
        if (reset) begin
            flt_r    <= 16'd0;
            shreg_r  <= 16'd0;
            result_r <= 16'd0;
            cnt_r    <= 4'd0;
            left_r   <= 1'b0;
            sat_r    <= 1'b0;
        end else begin
            case (state_r)
                RD_HI:  flt_r[15:8] <= mem_rd_data;
                RD_LO:  flt_r[7:0]  <= mem_rd_data;
                DECODE: begin
                    shreg_r <= zero_s ? 16'd0 : {5'd0, mant_s};
                    cnt_r   <= n_s;
                    left_r  <= left_s;
                    sat_r   <= sat_s;
                end
                SHIFT: begin
                    shreg_r <= left_r ? (shreg_r << 1) : (shreg_r >> 1);
                    cnt_r   <= cnt_r - 4'd1;
                end
                FINAL:  result_r <= result_s;
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so reads see the address in-cycle
    always_ff @(posedge CLK) begin
        if (reset) begin
            mem_addr_r    <= ADDR_ZERO;
            mem_wr_en_r   <= 1'b0;
            mem_wr_data_r <= 8'd0;
            halt_r        <= 1'b0;
        end else begin
            halt_r <= (state_next_s == DONE);
            case (state_next_s)
                RD_HI: begin
                    mem_addr_r    <= ADDR_F_HI;
                    mem_wr_en_r   <= 1'b0;
                    mem_wr_data_r <= 8'd0;
                end
                RD_LO: begin
                    mem_addr_r    <= ADDR_F_LO;
                    mem_wr_en_r   <= 1'b0;
                    mem_wr_data_r <= 8'd0;
                end
                WR_HI: begin
                    mem_addr_r    <= ADDR_R_HI;
                    mem_wr_en_r   <= 1'b1;
                    mem_wr_data_r <= result_s[15:8];
                end
                WR_LO: begin
                    mem_addr_r    <= ADDR_R_LO;
                    mem_wr_en_r   <= 1'b1;
                    mem_wr_data_r <= result_r[7:0];
                end
                default: begin
                    mem_addr_r    <= ADDR_ZERO;
                    mem_wr_en_r   <= 1'b0;
                    mem_wr_data_r <= 8'd0;
                end
            endcase
        end
    end

    // Strobe is masked by reset so an interrupted write never lands
    assign mem_wr_en   = mem_wr_en_r & ~reset;
    assign mem_addr    = mem_addr_r;
    assign mem_wr_data = mem_wr_data_r;
    assign halt        = halt_r;

endmodule

// File: tb/tb_flt2int_seq.sv
// Randomized and directed bench for flt2int_seq against an arithmetic
// reference model of half-precision to int16 truncating conversion.
module tb_flt2int_seq;

    localparam int AW = 8;

    logic          CLK = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    mem_rd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [7:0]    mem_wr_data;
    logic          halt;

    logic [7:0]    mem [0:255];
    int            checks = 0;
    int            fails  = 0;
    int            wr_cnt = 0;
    logic [15:0]   cur_exp = 16'd0;

    logic [15:0] dir_f   [13] = '{16'h3C00, 16'h3E00, 16'h4B00, 16'h0000, 16'h7B80,
                                  16'h7C00, 16'hC500, 16'hF800, 16'hFA00, 16'h7380,
                                  16'h4000, 16'h8000, 16'hB800};
    logic [15:0] dir_res [13] = '{16'h0001, 16'h0001, 16'h000E, 16'h0000, 16'h7FFF,
                                  16'h7FFF, 16'hFFFB, 16'h8000, 16'h8000, 16'h3C00,
                                  16'h0002, 16'h0000, 16'h0000};

    flt2int_seq #(.MEM_AW(AW)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .start       (start),
        .mem_rd_data (mem_rd_data),
        .mem_addr    (mem_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .halt        (halt)
    );

    always #5 CLK = ~CLK;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge CLK) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Value-level model: float value truncated toward zero, clamped to int16
    function automatic void model(input logic [15:0] f, output logic [15:0] res, output int n);
        int e, ex, mant, mag, v;
        e    = int'(f[14:10]);
        ex   = e - 15;
        mant = ((e != 0) ? 1024 : 0) + int'(f[9:0]);
        n    = 0;
        if (ex >= 15)      mag = 65536;
        else if (ex < 0)   mag = 0;
        else if (ex <= 10) begin mag = mant / (1 << (10 - ex)); n = 10 - ex; end
        else               begin mag = mant * (1 << (ex - 10)); n = ex - 10; end
        v = f[15] ? -mag : mag;
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        res = v[15:0];
    endfunction

    // Per-cycle bus checks: legal addresses, and write strobes carry the model result
    always @(negedge CLK) begin
        check("addr_legal", 32'(mem_addr == 0 || mem_addr == 4 || mem_addr == 5 ||
                                mem_addr == 6 || mem_addr == 7), 32'd1);
        if (mem_wr_en) begin
            wr_cnt++;
            check("wr_addr", 32'(mem_addr == 6 || mem_addr == 7), 32'd1);
            check("wr_data", 32'(mem_wr_data),
                  32'((mem_addr == 6) ? cur_exp[15:8] : cur_exp[7:0]));
            check("wr_in_reset", 32'(reset), 32'd0);
        end
    end

    task automatic load(input logic [15:0] f);
        mem[4] = f[15:8];
        mem[5] = f[7:0];
        mem[6] = 8'hA5;
        mem[7] = 8'h5A;
    endtask

    task automatic run_conv(input logic [15:0] f, input logic [15:0] pin,
                            input bit use_pin, input bit toggle);
        logic [15:0] res;
        int n, cyc;
        model(f, res, n);
        if (use_pin) check("model_pin", 32'(res), 32'(pin));
        load(f);
        cur_exp = res;
        wr_cnt  = 0;
        start = 1'b1;
        @(posedge CLK); #1;
        check("halt_clear", 32'(halt), 32'd0);
        start = 1'b0;
        @(posedge CLK); #1;
        cyc = 1;
        while (!halt && cyc < 40) begin
            start = (toggle && cyc >= 2 && cyc <= 4) ? cyc[0] : 1'b0;
            @(posedge CLK); #1;
            cyc++;
        end
        start = 1'b0;
        check("latency", 32'(cyc), 32'(n + 7));
        check("result_hi", 32'(mem[6]), 32'(res[15:8]));
        check("result_lo", 32'(mem[7]), 32'(res[7:0]));
        check("src_hi_kept", 32'(mem[4]), 32'(f[15:8]));
        check("src_lo_kept", 32'(mem[5]), 32'(f[7:0]));
        check("wr_count", 32'(wr_cnt), 32'd2);
        repeat (3) @(posedge CLK);
        #1;
        check("halt_hold", 32'(halt), 32'd1);
    endtask

    task automatic reset_mid(input logic [15:0] f, input int at_cyc, input logic [7:0] addr_req);
        wr_cnt = 0;
        load(f);
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        @(posedge CLK); #1;
        repeat (at_cyc - 1) @(posedge CLK);
        #1;
        check("pre_reset_addr", 32'(mem_addr), 32'(addr_req));
        reset = 1'b1;
        #1;
        check("wr_gated", 32'(mem_wr_en), 32'd0);
        @(posedge CLK); #1;
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wr_data), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            check("idle_addr", 32'(mem_addr), 32'd0);
            check("idle_halt", 32'(halt), 32'd0);
        end
        check("kept_hi", 32'(mem[6]), 32'h0A5);
        check("kept_lo", 32'(mem[7]), 32'h05A);
        check("rst_wr_count", 32'(wr_cnt), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_halt", 32'(halt), 32'd0);
        check("reset_addr", 32'(mem_addr), 32'd0);
        check("reset_wr_en", 32'(mem_wr_en), 32'd0);
        check("reset_wdata", 32'(mem_wr_data), 32'd0);
        reset = 1'b0;
        @(posedge CLK); #1;

        for (int i = 0; i < 13; i++) run_conv(dir_f[i], dir_res[i], 1'b1, (i == 10));

        // reset in SHIFT of 1.0 (cycle 6 of 17), then in WR_HI of 0.0 (cycle 5)
        reset_mid(16'h3C00, 6, 8'd0);
        reset_mid(16'h0000, 5, 8'd6);
        run_conv(16'h3C00, 16'h0001, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_conv(16'($urandom), 16'h0000, 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
